// File: rtl/osc_pkg.sv
// Shared types and constants for the oscillator scheduler: Q8.24 words, the
// state triple, the FSM encoding and the theta wrap helper used with OSC_SCHED_WRAP_EN.
package osc_pkg;

    typedef logic signed [31:0] q824_t;

    typedef struct packed {
        q824_t theta;
        q824_t y;
        q824_t z;
    } osc_triple_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMMIT,
        FINISH
    } osc_state_t;

    localparam q824_t TWO_PI_Q824    = 32'h06487ED5;
    localparam int    DEFAULT_SETTLE = 24;

    // A single correction is enough because one step moves theta by less than 2pi.
    function automatic q824_t wrap_theta(input q824_t t);
        if (t < 0) return t + TWO_PI_Q824;
        if (t >= TWO_PI_Q824) return t - TWO_PI_Q824;
        return t;
    endfunction

endpackage

// File: rtl/osc_state_ram.sv
// N_OSC x 96-bit oscillator state register file: one synchronous write port and
// one combinational read port, cleared by reset.
module osc_state_ram
    import osc_pkg::*;
#(
    parameter int N_OSC = 4,
    parameter int IDX_W = 2
) (
    input  logic             slow_clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  osc_triple_t      wdata,
    input  logic [IDX_W-1:0] raddr,
    output osc_triple_t      rdata
);

    osc_triple_t mem [N_OSC];

    // NOTE: every slot has a reset value, so this maps to flops rather than a RAM macro.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_OSC; i++) mem[i] <= '0;
        end else if (we && int'(waddr) < N_OSC) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < N_OSC) ? mem[raddr] : '0;

endmodule

// File: rtl/oscillator_scheduler.sv
// Time-multiplexes N_OSC Q8.24 oscillators through one external step datapath.
// Define OSC_SCHED_WRAP_EN to wrap each committed theta into [0, 2pi).
module oscillator_scheduler
    import osc_pkg::*;
#(
    parameter  int N_OSC  = 4,
    parameter  int SETTLE = DEFAULT_SETTLE,
    localparam int IDX_W  = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
    input  logic             slow_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_steps,
    input  logic             abort,
    input  logic             load_we,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [31:0]      load_theta,
    input  logic [31:0]      load_y,
    input  logic [31:0]      load_z,
    output logic [31:0]      dp_theta,
    output logic [31:0]      dp_y,
    output logic [31:0]      dp_z,
    output logic [31:0]      dp_n,
    input  logic [31:0]      dp_theta1,
    input  logic [31:0]      dp_y1,
    input  logic [31:0]      dp_z1,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [31:0]      out_theta,
    output logic [31:0]      out_y,
    output logic [31:0]      out_z
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    osc_state_t       state;
    logic [15:0]      num_steps_q;
    logic [15:0]      step;
    logic [15:0]      step_inc;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] settle_cnt;
    logic             last_idx;

    osc_triple_t      rd_triple;
    osc_triple_t      commit_triple;
    osc_triple_t      wr_triple;
    logic             load_sel;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    q824_t            commit_theta;

`ifdef OSC_SCHED_WRAP_EN
    assign commit_theta = wrap_theta(dp_theta1);
`else
    assign commit_theta = dp_theta1;
`endif

    assign commit_triple = '{theta: commit_theta, y: dp_y1, z: dp_z1};

    // Loads only land in IDLE; an abort in COMMIT suppresses the write.
    assign load_sel  = (state == IDLE) && load_we;
    assign wr_en     = load_sel || ((state == COMMIT) && !abort);
    assign wr_idx    = load_sel ? load_idx : idx;
    assign wr_triple = load_sel ? '{theta: load_theta, y: load_y, z: load_z} : commit_triple;

    assign last_idx = (idx == IDX_W'(N_OSC - 1));
    assign step_inc = step + 16'd1;

    osc_state_ram #(
        .N_OSC (N_OSC),
        .IDX_W (IDX_W)
    ) u_state_ram (
        .slow_clk (slow_clk),
        .rst      (rst),
        .we       (wr_en),
        .waddr    (wr_idx),
        .wdata    (wr_triple),
        .raddr    (idx),
        .rdata    (rd_triple)
    );

    // NOTE: non-blocking updates throughout, so every branch sees pre-edge state.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num_steps_q <= '0;
            step        <= '0;
            idx         <= '0;
            settle_cnt  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
            out_theta   <= '0;
            out_y       <= '0;
            out_z       <= '0;
            dp_theta    <= '0;
            dp_y        <= '0;
            dp_z        <= '0;
            dp_n        <= '0;
        end else begin
            done      <= 1'b0;
            out_valid <= 1'b0;
            if (state != IDLE && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            num_steps_q <= num_steps;
                            idx         <= '0;
                            step        <= '0;
                            busy        <= 1'b1;
                            state       <= (num_steps == 16'd0) ? FINISH : ISSUE;
                        end
                    end
                    ISSUE: begin
                        dp_theta   <= rd_triple.theta;
                        dp_y       <= rd_triple.y;
                        dp_z       <= rd_triple.z;
                        dp_n       <= {step[7:0], 24'h000000};
                        settle_cnt <= CNT_W'(SETTLE - 1);
                        state      <= WAIT;
                    end
                    WAIT: begin
                        if (settle_cnt == '0) state <= COMMIT;
                        else settle_cnt <= settle_cnt - 1'b1;
                    end
                    COMMIT: begin
                        out_valid <= 1'b1;
                        out_idx   <= idx;
                        out_theta <= commit_theta;
                        out_y     <= dp_y1;
                        out_z     <= dp_z1;
                        if (last_idx) begin
                            idx   <= '0;
                            step  <= step_inc;
                            state <= (step_inc == num_steps_q) ? FINISH : ISSUE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ISSUE;
                        end
                    end
                    FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oscillator_scheduler.sv
// Randomized self-checking bench for oscillator_scheduler with a run-level reference
// model; honours OSC_SCHED_WRAP_EN for the expected theta.
module tb_oscillator_scheduler;
    import osc_pkg::*;

    localparam int N_OSC  = 4;
    localparam int SETTLE = 24;
    localparam int STEP_CYC = SETTLE + 2;

    typedef struct {
        int          edge_c;
        int          idx;
        osc_triple_t val;
    } commit_t;

    logic        slow_clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_steps = '0;
    logic        abort = 1'b0;
    logic        load_we = 1'b0;
    logic [1:0]  load_idx = '0;
    logic [31:0] load_theta = '0, load_y = '0, load_z = '0;
    logic [31:0] dp_theta, dp_y, dp_z, dp_n;
    logic [31:0] dp_theta1, dp_y1, dp_z1;
    logic        busy, done, out_valid;
    logic [1:0]  out_idx;
    logic [31:0] out_theta, out_y, out_z;

    int          n_total = 0;
    int          n_bad = 0;
    logic [31:0] theta_inc = '0;
    logic [31:0] last_theta0 = '0;
    osc_triple_t mem_m [N_OSC];
    osc_triple_t dp_next;

    always #5 slow_clk = ~slow_clk;

    oscillator_scheduler #(.N_OSC(N_OSC), .SETTLE(SETTLE)) dut (
        .slow_clk (slow_clk),   .rst (rst),
        .start (start),         .num_steps (num_steps),   .abort (abort),
        .load_we (load_we),     .load_idx (load_idx),
        .load_theta (load_theta), .load_y (load_y),       .load_z (load_z),
        .dp_theta (dp_theta),   .dp_y (dp_y),             .dp_z (dp_z),     .dp_n (dp_n),
        .dp_theta1 (dp_theta1), .dp_y1 (dp_y1),           .dp_z1 (dp_z1),
        .busy (busy),           .done (done),
        .out_valid (out_valid), .out_idx (out_idx),
        .out_theta (out_theta), .out_y (out_y),           .out_z (out_z)
    );

    // External step datapath stand-in: any deterministic function of state and n.
    function automatic osc_triple_t dp_func(osc_triple_t c, logic [31:0] n, logic [31:0] inc);
        osc_triple_t r;
        r.theta = c.theta + inc;
        r.y     = c.y + (c.z >>> 3) + n;
        r.z     = c.z - (c.y >>> 3);
        return r;
    endfunction

    always_comb dp_next = dp_func('{theta: dp_theta, y: dp_y, z: dp_z}, dp_n, theta_inc);
    assign dp_theta1 = dp_next.theta;
    assign dp_y1     = dp_next.y;
    assign dp_z1     = dp_next.z;

    function automatic logic [31:0] model_wrap(logic [31:0] t);
`ifdef OSC_SCHED_WRAP_EN
        longint v;
        v = longint'($signed(t));
        if (v >= longint'(32'h06487ED5)) v = v - longint'(32'h06487ED5);
        else if (v < 0) v = v + longint'(32'h06487ED5);
        return v[31:0];
`else
        return t;
`endif
    endfunction

    function automatic osc_triple_t model_step(osc_triple_t c, int s);
        osc_triple_t r;
        r = dp_func(c, 32'(s) << 24, theta_inc);
        r.theta = model_wrap(r.theta);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int i, input osc_triple_t v);
        @(negedge slow_clk);
        load_we = 1'b1; load_idx = 2'(i);
        load_theta = v.theta; load_y = v.y; load_z = v.z;
        @(posedge slow_clk); #1;
        load_we = 1'b0;
        mem_m[i] = v;
    endtask

    // Runs ns steps; abort_at is the edge (counted from the start edge) carrying abort,
    // 0 means abort together with start, negative means no abort.
    task automatic run(input int ns, input int abort_at, input bit noise,
                       input bit ld, input int ld_idx, input osc_triple_t ld_val);
        commit_t q[$];
        commit_t e;
        bit      aborted, exp_v, exp_d;
        int      end_c;
        aborted = abort_at > 0;
        if (ld) mem_m[ld_idx] = ld_val;
        for (int s = 0; s < ns; s++) begin
            for (int i = 0; i < N_OSC; i++) begin
                int ec;
                ec = (s * N_OSC + i + 1) * STEP_CYC;
                if (!aborted || ec < abort_at) begin
                    mem_m[i] = model_step(mem_m[i], s);
                    q.push_back('{edge_c: ec, idx: i, val: mem_m[i]});
                end
            end
        end
        end_c = aborted ? abort_at : ns * N_OSC * STEP_CYC + 1;

        @(negedge slow_clk);
        start = 1'b1; num_steps = 16'(ns); abort = (abort_at == 0);
        if (ld) begin
            load_we = 1'b1; load_idx = 2'(ld_idx);
            load_theta = ld_val.theta; load_y = ld_val.y; load_z = ld_val.z;
        end
        @(posedge slow_clk); #1;
        start = 1'b0; load_we = 1'b0; abort = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);

        for (int c = 1; c <= end_c + 3; c++) begin
            abort = (c == abort_at);
            if (noise && c < end_c) begin
                if ($urandom_range(0, 3) == 0) begin
                    start = 1'b1; num_steps = 16'($urandom_range(0, 5));
                end
                if ($urandom_range(0, 3) == 0) begin
                    load_we = 1'b1; load_idx = 2'($urandom_range(0, 3));
                    load_theta = $urandom; load_y = $urandom; load_z = $urandom;
                end
            end
            @(posedge slow_clk); #1;
            start = 1'b0; load_we = 1'b0; abort = 1'b0;
            exp_v = (q.size() > 0) && (q[0].edge_c == c);
            if (out_valid || exp_v) begin
                check("out_valid", 32'(out_valid), 32'(exp_v));
                if (exp_v) begin
                    e = q.pop_front();
                    check("out_idx", 32'(out_idx), 32'(e.idx));
                    check("out_theta", out_theta, e.val.theta);
                    check("out_y", out_y, e.val.y);
                    check("out_z", out_z, e.val.z);
                    if (e.idx == 0) last_theta0 = out_theta;
                end
            end
            exp_d = !aborted && (c == end_c);
            if (done || exp_d) check("done", 32'(done), 32'(exp_d));
            if (c == end_c) check("busy_end", 32'(busy), 32'd0);
        end
        check("commits_left", 32'(q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idx"}, 32'(out_idx), 32'd0);
        check({tag, "_otheta"}, out_theta, 32'd0);
        check({tag, "_oy"}, out_y, 32'd0);
        check({tag, "_dtheta"}, dp_theta, 32'd0);
        check({tag, "_dy"}, dp_y, 32'd0);
        check({tag, "_dn"}, dp_n, 32'd0);
    endtask

    initial begin
        osc_triple_t v;
        for (int i = 0; i < N_OSC; i++) mem_m[i] = '0;

        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge slow_clk);
        @(negedge slow_clk) rst = 1'b0;

        // Single step on four oscillators: commits 26 cycles apart, done at 105.
        theta_inc = 32'h00100000;
        load(0, '{theta: 32'h0, y: 32'h01000000, z: 32'h0});
        run(1, -1, 1'b0, 1'b0, 0, '0);

        // Zero steps: done right after start, nothing committed.
        run(0, -1, 1'b0, 1'b0, 0, '0);

        // Load coincident with start; theta crosses 2pi on the first commit.
        theta_inc = 32'h01000000;
        run(1, -1, 1'b0, 1'b1, 0, '{theta: 32'h06000000, y: 32'h00800000, z: 32'hFF000000});
`ifdef OSC_SCHED_WRAP_EN
        check("wrap_theta0", last_theta0, 32'h00B7812B);
`else
        check("wrap_theta0", last_theta0, 32'h07000000);
`endif

        // Random initial states and step counts, one run with ignored start/load noise.
        for (int r = 0; r < 3; r++) begin
            theta_inc = 32'($urandom_range(0, 32'h00FFFFFF));
            for (int i = 0; i < N_OSC; i++) begin
                v.theta = 32'($urandom_range(0, 32'h06487ED4));
                v.y = $urandom;
                v.z = $urandom;
                load(i, v);
            end
            run($urandom_range(1, 3), -1, r == 1, 1'b0, 0, '0);
        end

        // Abort together with start in IDLE: start wins.
        run(1, 0, 1'b0, 1'b0, 0, '0);
        // Abort on a COMMIT edge: that commit is dropped.
        run(2, 2 * STEP_CYC, 1'b0, 1'b0, 0, '0);
        // Abort in WAIT of idx2, third step; the follow-up run exposes memory contents.
        run(4, 10 * STEP_CYC + 14, 1'b0, 1'b0, 0, '0);
        run(1, -1, 1'b0, 1'b0, 0, '0);

        // Asynchronous reset in mid-WAIT, then a clean run from zeroed state.
        @(negedge slow_clk);
        start = 1'b1; num_steps = 16'd2;
        @(posedge slow_clk); #1;
        start = 1'b0;
        repeat (9) @(posedge slow_clk);
        #3 rst = 1'b1;
        #1 check_all_zero("midrun_rst");
        for (int i = 0; i < N_OSC; i++) mem_m[i] = '0;
        @(negedge slow_clk) rst = 1'b0;
        repeat (3) begin
            @(posedge slow_clk); #1;
            check("post_rst_done", 32'(done), 32'd0);
        end
        theta_inc = 32'h00200000;
        run(2, -1, 1'b0, 1'b0, 0, '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/oscillator_scheduler.md
OSCILLATOR_SCHEDULER -- requirements
Module: oscillator_scheduler

Interface
REQ-001 Parameter N_OSC, default 4: number of oscillators time-multiplexed onto one oscillator step datapath.
REQ-002 Parameter SETTLE, default 24: slow_clk cycles the datapath needs to settle after its inputs change.
REQ-003 slow_clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  single-cycle request to run num_steps steps on all oscillators.
REQ-005 num_steps  in  16  step count, sampled when start is accepted.
REQ-006 abort  in  1  terminate the run at the next edge.
REQ-007 load_we  in  1, load_idx  in  clog2(N_OSC), load_theta/load_y/load_z  in  32 each: initial-state write, Q8.24.
REQ-008 dp_theta/dp_y/dp_z  out  32 each: current oscillator state driven to the datapath.
REQ-009 dp_n  out  32: step index in Q8.24 (integer step << 24).
REQ-010 dp_theta1/dp_y1/dp_z1  in  32 each: next state returned by the datapath.
REQ-011 busy  out  1; done  out  1 (one-cycle pulse).
REQ-012 out_valid  out  1, out_idx  out  clog2(N_OSC), out_theta/out_y/out_z  out  32: committed-state stream; there is no backpressure.

Function
REQ-013 State memory SHALL hold N_OSC triples (theta, y, z) as 32-bit signed Q8.24 values.
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, COMMIT and FINISH.
REQ-015 In IDLE with start=1, num_steps is latched, osc index and step counter are cleared, busy rises, and the FSM goes to ISSUE; if num_steps=0 it goes to FINISH instead.
REQ-016 ISSUE SHALL register the indexed triple onto dp_* and drive dp_n=step<<24, then go to WAIT with the settle counter loaded to SETTLE-1.
REQ-017 WAIT SHALL decrement the settle counter and go to COMMIT when it reaches 0, so dp_* are held stable for exactly SETTLE cycles.
REQ-018 COMMIT SHALL write dp_*1 into the indexed memory slot and pulse out_valid for one cycle with out_idx and the written values.
REQ-019 After COMMIT, the index increments; at N_OSC-1 it wraps to 0 and the step increments; when step reaches num_steps the FSM goes to FINISH, otherwise to ISSUE.
REQ-020 FINISH SHALL pulse done for one cycle, clear busy and return to IDLE.
REQ-021 Each oscillator step SHALL take SETTLE+2 cycles, so a run takes num_steps*N_OSC*(SETTLE+2)+1 cycles from start to done.
REQ-022 start and load_we while busy SHALL be ignored.
REQ-023 A load_we in IDLE SHALL write the triple in 1 cycle; if load_we and start arrive together, the load completes first and the run uses the loaded value.
REQ-024 abort in any non-IDLE state SHALL go to IDLE on the next edge with no COMMIT and no done pulse; memory keeps the last committed values.
REQ-025 abort and start arriving together in IDLE: start wins.
REQ-026 Step counter is 16-bit; dp_n SHALL be zero-extended before the shift.

Reset
REQ-027 On rst: FSM=IDLE, busy=0, done=0, out_valid=0, out_idx=0, out_*=0, dp_*=0, dp_n=0, all counters=0, all memory slots=0.
REQ-028 rst mid-run SHALL discard the run immediately and emit no done pulse.

Configuration
REQ-029 Macro OSC_SCHED_WRAP_EN, when defined: the committed theta is wrapped into [0, 2pi) (2pi = 32'h06487ED5) by one conditional add or subtract, with the wrapped value both stored and streamed.
REQ-030 Without OSC_SCHED_WRAP_EN, theta is stored unmodified; all other behaviour is identical.

Structure
REQ-031 Shared package osc_pkg SHALL hold the Q8.24 word typedef, the FSM state enum, TWO_PI_Q824 and the default SETTLE.
REQ-032 One sub-module, osc_state_ram, SHALL provide the N_OSC x 96-bit register file with one write port and one combinational read port.

Verification
REQ-033 Load idx0 = (0, 1.0, 0); start, num_steps=1, N_OSC=4, SETTLE=24 -> 4 out_valid pulses 26 cycles apart; done at cycle 105.
REQ-034 Start with num_steps=0 -> done one cycle after start, no out_valid, memory unchanged.
REQ-035 Datapath model returning theta+0x01000000 with theta=0x06000000 -> wrap enabled: stored 0x00B7812B; wrap disabled: stored 0x07000000.
REQ-036 abort during WAIT of idx2 in step 3 -> busy=0 next cycle, no done pulse, idx2 still holds its step-2 value.
REQ-037 Assert rst mid-WAIT -> all outputs 0 asynchronously; a new start then runs normally from zeroed state.
REQ-038 Pulse start and load_we while busy -> both ignored, and the sequence and memory match a run without them.
